// File: rtl/out_checksum_pkg.sv
// Shared types and constants for the out_checksum output stage.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package out_checksum_pkg;

  // Width of one serialised output symbol.
  localparam int NIB_W = 4;

  // Bit positions inside the trailing status nibble.
  localparam int ST_CNT_OK = 3;
  localparam int ST_OVR    = 2;
  localparam int ST_SAT    = 1;

  // Run-tracking FSM encodings.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/out_checksum_nibble_serializer.sv
// Shifts a signature-plus-status word out MSB nibble first on registered
// data_out/data_valid pins. The final (status) nibble is OR-ed with a late
// sticky-flag input so flags raised while draining still reach the pins.
module nibble_serializer
  import out_checksum_pkg::*;
#(
  parameter int DIN_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [DIN_WIDTH+3:0]   load_word_i,
  input  logic [NIB_W-1:0]       tail_i,
  output logic [NIB_W-1:0]       data_out_o,
  output logic                   data_valid_o,
  output logic                   busy_o
);

  localparam int NNIB  = DIN_WIDTH / NIB_W;
  localparam int REM_W = $clog2(NNIB + 1);

  logic [DIN_WIDTH-1:0] shreg_q, shreg_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [NIB_W-1:0]     dout_q, dout_d;
  logic                 dv_q, dv_d;

  // Next nibble selection: load emits the top nibble at once, then one per cycle.
  always_comb begin
    shreg_d = shreg_q;
    rem_d   = rem_q;
    dout_d  = '0;
    dv_d    = 1'b0;
    if (load_i) begin
      dout_d  = load_word_i[DIN_WIDTH+3 -: NIB_W];
      dv_d    = 1'b1;
      shreg_d = load_word_i[DIN_WIDTH-1:0];
      rem_d   = REM_W'(NNIB);
    end else if (rem_q != '0) begin
      dv_d   = 1'b1;
      dout_d = shreg_q[DIN_WIDTH-1 -: NIB_W];
      if (rem_q == REM_W'(1)) begin
        dout_d = dout_d | tail_i;
      end
      shreg_d = shreg_q << NIB_W;
      rem_d   = rem_q - REM_W'(1);
    end
  end

  // Shift register, remaining count and registered output pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
    end
  end

  assign data_out_o   = dout_q;
  assign data_valid_o = dv_q;
  // Low once the status nibble is being presented, so the FSM leaves DRAIN in step.
  assign busy_o       = (rem_q != '0);

endmodule

// File: rtl/out_checksum.sv
// Folds one kernel run's result stream into a rotate-XOR signature and
// serialises signature plus status onto a 4-bit pin bus on ap_done.
// Handshake: a word transfers in every cycle din_write=1 while in ACCUM;
// full_n is low only in DRAIN, and writes seen there are dropped and flagged.
module out_checksum
  import out_checksum_pkg::*;
#(
  parameter int DIN_WIDTH = 32,
  parameter int EXP_COUNT = 64,
  parameter int CNT_W     = `CLOG2(EXP_COUNT) + 1
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  input  logic                 ap_done,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_write,
  output logic                 full_n,
  output logic [NIB_W-1:0]     data_out,
  output logic                 data_valid,
  output logic [1:0]           dbg_state_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic [DIN_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovr_q, ovr_d;
  logic                 full_n_q, full_n_d;

  logic [DIN_WIDTH-1:0] acc_fold;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 ser_load;
  logic                 ser_busy;
  logic [NIB_W-1:0]     status;
  logic [NIB_W-1:0]     tail;

  assign acc_fold = {acc_q[DIN_WIDTH-2:0], acc_q[DIN_WIDTH-1]} ^ din;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // FSM next state, accumulator/counter update and serializer load.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    ser_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovr_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (din_write) begin
          acc_d = acc_fold;
          cnt_d = cnt_inc;
        end
        if (ap_done) begin
          ser_load = 1'b1;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (din_write) begin
          ovr_d = 1'b1;
        end
        if (!ser_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    full_n_d = (state_d != S_DRAIN);
  end

  // Status captured at load time; the same-cycle write is already in cnt_d.
  always_comb begin
    status            = '0;
    status[ST_CNT_OK] = (cnt_d == CNT_W'(EXP_COUNT));
    status[ST_OVR]    = ovr_q;
    status[ST_SAT]    = (cnt_d == CNT_MAX);
    tail              = '0;
    tail[ST_OVR]      = ovr_d;
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
      full_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
      full_n_q <= full_n_d;
    end
  end

  nibble_serializer #(
    .DIN_WIDTH(DIN_WIDTH)
  ) u_ser (
    .clk_i        (ap_clk),
    .rst_i        (ap_rst),
    .load_i       (ser_load),
    .load_word_i  ({acc_d, status}),
    .tail_i       (tail),
    .data_out_o   (data_out),
    .data_valid_o (data_valid),
    .busy_o       (ser_busy)
  );

  assign full_n      = full_n_q;
  assign dbg_state_o = state_q;

endmodule
